// File: rtl/command_sequencer_pkg.sv
// rtl/command_sequencer_pkg.sv - instruction codes, done-line indices, state and error encodings
package saber_seq_pkg;

  localparam logic [4:0] INS_NOP        = 5'd0;
  localparam logic [4:0] INS_SHAKE_LO   = 5'd1;
  localparam logic [4:0] INS_SHAKE_HI   = 5'd5;
  localparam logic [4:0] INS_VMUL       = 5'd6;
  localparam logic [4:0] INS_ADDROUND   = 5'd7;
  localparam logic [4:0] INS_ADDPACK    = 5'd8;
  localparam logic [4:0] INS_BS2POLVECP = 5'd9;
  localparam logic [4:0] INS_VMUL_ALT   = 5'd10;
  localparam logic [4:0] INS_UNPACK     = 5'd11;
  localparam logic [4:0] INS_COPY       = 5'd12;
  localparam logic [4:0] INS_SAMPLER    = 5'd13;
  localparam logic [4:0] INS_VERIFY     = 5'd14;
  localparam logic [4:0] INS_CMOV       = 5'd15;
  localparam logic [4:0] INS_TIMER      = 5'd17;
  localparam logic [4:0] INS_HALT       = 5'd31;

  localparam int DN_SHAKE      = 0;
  localparam int DN_VMUL       = 1;
  localparam int DN_ADDROUND   = 2;
  localparam int DN_ADDPACK    = 3;
  localparam int DN_BS2POLVECP = 4;
  localparam int DN_UNPACK     = 5;
  localparam int DN_COPY       = 6;
  localparam int DN_SAMPLER    = 7;
  localparam int DN_VERIFY     = 8;
  localparam int DN_CMOV       = 9;
  localparam int DN_TIMER      = 10;
  localparam int DONE_W        = 11;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL_INS = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT     = 2'd2;

  localparam logic [34:0] CMD_NOP = 35'd0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT,
    ST_CLEAR,
    ST_ERROR
  } seq_state_e;

endpackage

// File: rtl/command_sequencer_if.sv
// rtl/command_sequencer_if.sv - program memory read port plus compute core command/done bus
interface command_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              prog_en;
  logic [ADDR_W-1:0] prog_addr;
  logic [35:0]       prog_data;
  logic [34:0]       command_in;
  logic              command_we0;
  logic              command_we1;
  logic              done_shake;
  logic              done_vmul;
  logic              done_addround;
  logic              done_addpack;
  logic              done_bs2polvecp;
  logic              done_unpack;
  logic              done_copy;
  logic              done_sampler;
  logic              done_verify;
  logic              done_cmov;
  logic              done_timer;

  modport master (
    output prog_en, prog_addr, command_in, command_we0, command_we1,
    input  prog_data, done_shake, done_vmul, done_addround, done_addpack,
           done_bs2polvecp, done_unpack, done_copy, done_sampler, done_verify,
           done_cmov, done_timer
  );

  modport slave (
    input  prog_en, prog_addr, command_in, command_we0, command_we1,
    output prog_data, done_shake, done_vmul, done_addround, done_addpack,
           done_bs2polvecp, done_unpack, done_copy, done_sampler, done_verify,
           done_cmov, done_timer
  );
endinterface

// File: rtl/command_sequencer_ins_done_select.sv
// rtl/command_sequencer_ins_done_select.sv - maps an instruction code to its legality and engine done line
module ins_done_select
  import saber_seq_pkg::*;
(
  input  logic [4:0]        ins_i,
  input  logic [DONE_W-1:0] done_i,
  output logic              legal_o,
  output logic              done_o
);

  always_comb begin
    legal_o = 1'b1;
    done_o  = 1'b0;
    case (ins_i) inside
      [INS_SHAKE_LO:INS_SHAKE_HI]: done_o = done_i[DN_SHAKE];
      INS_VMUL, INS_VMUL_ALT:      done_o = done_i[DN_VMUL];
      INS_ADDROUND:                done_o = done_i[DN_ADDROUND];
      INS_ADDPACK:                 done_o = done_i[DN_ADDPACK];
      INS_BS2POLVECP:              done_o = done_i[DN_BS2POLVECP];
      INS_UNPACK:                  done_o = done_i[DN_UNPACK];
      INS_COPY:                    done_o = done_i[DN_COPY];
      INS_SAMPLER:                 done_o = done_i[DN_SAMPLER];
      INS_VERIFY:                  done_o = done_i[DN_VERIFY];
      INS_CMOV:                    done_o = done_i[DN_CMOV];
      INS_TIMER:                   done_o = done_i[DN_TIMER];
      default:                     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/command_sequencer.sv
// rtl/command_sequencer.sv - fetches program words, drives core command registers, waits on engine done
module command_sequencer
  import saber_seq_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              busy,
  output logic              seq_done,
  output logic              seq_error,
  output logic [1:0]        error_code,
  command_sequencer_if.master bus
);

  seq_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 guard_q, guard_d;
  logic [34:0]          cmd_q, cmd_d;
  logic                 we0_q, we0_d;
  logic                 we1_q, we1_d;
  logic                 prog_en_q, prog_en_d;
  logic [ADDR_W-1:0]    prog_addr_q, prog_addr_d;
  logic                 busy_q, busy_d;
  logic                 seq_done_q, seq_done_d;
  logic                 seq_error_q, seq_error_d;
  logic [1:0]           err_code_q, err_code_d;

  logic [DONE_W-1:0]    done_vec;
  logic [4:0]           sel_ins;
  logic                 sel_legal;
  logic                 sel_done;
  logic [ADDR_W-1:0]    pc_inc;
  logic [TIMEOUT_W-1:0] wd_inc;

  assign done_vec = {bus.done_timer, bus.done_cmov, bus.done_verify, bus.done_sampler,
                     bus.done_copy, bus.done_unpack, bus.done_bs2polvecp, bus.done_addpack,
                     bus.done_addround, bus.done_vmul, bus.done_shake};

  // DECODE judges the incoming word; in WAIT the issued instruction is still on command_in.
  assign sel_ins = (state_q == ST_DECODE) ? bus.prog_data[4:0] : cmd_q[4:0];

  ins_done_select u_sel (
    .ins_i   (sel_ins),
    .done_i  (done_vec),
    .legal_o (sel_legal),
    .done_o  (sel_done)
  );

  assign pc_inc = pc_q + 1'b1;
  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    wd_d        = wd_q;
    guard_d     = guard_q;
    cmd_d       = cmd_q;
    we0_d       = 1'b0;
    we1_d       = 1'b0;
    prog_en_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    seq_done_d  = 1'b0;
    seq_error_d = seq_error_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d        = start_addr;
          prog_en_d   = 1'b1;
          prog_addr_d = start_addr;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        if (bus.prog_data[35]) begin
          cmd_d       = bus.prog_data[34:0];
          we1_d       = 1'b1;
          pc_d        = pc_inc;
          prog_en_d   = 1'b1;
          prog_addr_d = pc_inc;
          state_d     = ST_FETCH;
        end else if (bus.prog_data[4:0] == INS_NOP) begin
          cmd_d       = bus.prog_data[34:0];
          we0_d       = 1'b1;
          pc_d        = pc_inc;
          prog_en_d   = 1'b1;
          prog_addr_d = pc_inc;
          state_d     = ST_FETCH;
        end else if (bus.prog_data[4:0] == INS_HALT) begin
          seq_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (sel_legal) begin
          cmd_d   = bus.prog_data[34:0];
          we0_d   = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          cmd_d       = CMD_NOP;
          we0_d       = 1'b1;
          seq_error_d = 1'b1;
          err_code_d  = ERR_ILLEGAL_INS;
          state_d     = ST_ERROR;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        guard_d = 1'b0;
        state_d = ST_GUARD;
      end
      // Done lines may still show the previous run until the engine reset settles.
      ST_GUARD: begin
        guard_d = 1'b1;
        if (guard_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_done) begin
          cmd_d   = CMD_NOP;
          we0_d   = 1'b1;
          state_d = ST_CLEAR;
        end else if (&wd_inc) begin
          cmd_d       = CMD_NOP;
          we0_d       = 1'b1;
          seq_error_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = ST_ERROR;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_CLEAR: begin
        pc_d        = pc_inc;
        prog_en_d   = 1'b1;
        prog_addr_d = pc_inc;
        state_d     = ST_FETCH;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      wd_q        <= '0;
      guard_q     <= 1'b0;
      cmd_q       <= '0;
      we0_q       <= 1'b0;
      we1_q       <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_addr_q <= '0;
      busy_q      <= 1'b0;
      seq_done_q  <= 1'b0;
      seq_error_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      wd_q        <= wd_d;
      guard_q     <= guard_d;
      cmd_q       <= cmd_d;
      we0_q       <= we0_d;
      we1_q       <= we1_d;
      prog_en_q   <= prog_en_d;
      prog_addr_q <= prog_addr_d;
      busy_q      <= busy_d;
      seq_done_q  <= seq_done_d;
      seq_error_q <= seq_error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.prog_en     = prog_en_q;
  assign bus.prog_addr   = prog_addr_q;
  assign bus.command_in  = cmd_q;
  assign bus.command_we0 = we0_q;
  assign bus.command_we1 = we1_q;
  assign busy            = busy_q;
  assign seq_done        = seq_done_q;
  assign seq_error       = seq_error_q;
  assign error_code      = err_code_q;

endmodule

// File: tb/tb_command_sequencer.sv
// tb/tb_command_sequencer.sv - scoreboard bench for command_sequencer (default and 4-bit watchdog instances)
module tb_command_sequencer;

  typedef enum int {EV_WE0, EV_WE1, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [34:0] val;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, start_a, start_b;
  logic [7:0]  sa_a, sa_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b;
  logic [1:0]  code_a, code_b;
  logic [10:0] dn_a, dn_b;
  logic [35:0] mem [256];

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  iss_cyc_a, nop_cyc_a, iss_cyc_b, nop_cyc_b, err_cyc_b;

  command_sequencer_if #(.ADDR_W(8)) ifa ();
  command_sequencer_if #(.ADDR_W(8)) ifb ();

  command_sequencer #(.ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .start_addr(sa_a), .busy(busy_a),
    .seq_done(done_a), .seq_error(err_a), .error_code(code_a), .bus(ifa.master)
  );

  command_sequencer #(.ADDR_W(8), .TIMEOUT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .start_addr(sa_b), .busy(busy_b),
    .seq_done(done_b), .seq_error(err_b), .error_code(code_b), .bus(ifb.master)
  );

  always_ff @(posedge clk) begin
    if (ifa.prog_en) ifa.prog_data <= mem[ifa.prog_addr];
    if (ifb.prog_en) ifb.prog_data <= mem[ifb.prog_addr];
  end

  assign {ifa.done_timer, ifa.done_cmov, ifa.done_verify, ifa.done_sampler, ifa.done_copy,
          ifa.done_unpack, ifa.done_bs2polvecp, ifa.done_addpack, ifa.done_addround,
          ifa.done_vmul, ifa.done_shake} = dn_a;
  assign {ifb.done_timer, ifb.done_cmov, ifb.done_verify, ifb.done_sampler, ifb.done_copy,
          ifb.done_unpack, ifb.done_bs2polvecp, ifb.done_addpack, ifb.done_addround,
          ifb.done_vmul, ifb.done_shake} = dn_b;

  task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input bit which, input ev_kind_e kind, input logic [34:0] val);
    ev_t e;
    checks++;
    if ((which ? qb.size() : qa.size()) == 0) begin
      errors++;
      $display("FAIL sb_%0d unexpected: got kind %0d value %0h expected no event", which, kind, val);
    end else begin
      e = which ? qb.pop_front() : qa.pop_front();
      if (e.kind != kind || e.val !== val) begin
        errors++;
        $display("FAIL sb_%0d: got kind %0d value %0h expected kind %0d value %0h",
                 which, kind, val, e.kind, e.val);
      end
    end
  endtask

  task automatic push(input bit which, input ev_kind_e kind, input logic [34:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    if (which) qb.push_back(e);
    else qa.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever either DUT presents a strobe or a new error.
  initial begin
    bit seen_a, seen_b;
    seen_a = 1'b0;
    seen_b = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.command_we0 || ifa.command_we1)
        chk("we_excl_a", 35'(ifa.command_we0 & ifa.command_we1), 35'd0);
      if (ifa.command_we1) sb_pop(0, EV_WE1, ifa.command_in);
      if (ifa.command_we0) begin
        sb_pop(0, EV_WE0, ifa.command_in);
        if (ifa.command_in != 35'd0) iss_cyc_a = cyc;
        else nop_cyc_a = cyc;
      end
      if (done_a) sb_pop(0, EV_DONE, {27'd0, ifa.prog_addr});
      if (err_a && !seen_a) sb_pop(0, EV_ERR, {33'd0, code_a});
      seen_a = err_a;

      if (ifb.command_we0 || ifb.command_we1)
        chk("we_excl_b", 35'(ifb.command_we0 & ifb.command_we1), 35'd0);
      if (ifb.command_we1) sb_pop(1, EV_WE1, ifb.command_in);
      if (ifb.command_we0) begin
        sb_pop(1, EV_WE0, ifb.command_in);
        if (ifb.command_in != 35'd0) iss_cyc_b = cyc;
        else nop_cyc_b = cyc;
      end
      if (done_b) sb_pop(1, EV_DONE, {27'd0, ifb.prog_addr});
      if (err_b && !seen_b) begin
        sb_pop(1, EV_ERR, {33'd0, code_b});
        err_cyc_b = cyc;
      end
      seen_b = err_b;
    end
  end

  task automatic pulse_start(input bit which, input logic [7:0] addr);
    @(negedge clk);
    if (which) begin start_b = 1'b1; sa_b = addr; end
    else begin start_a = 1'b1; sa_a = addr; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic pulse_rst(input bit which);
    @(negedge clk);
    if (which) rst_b = 1'b1;
    else rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
  endtask

  task automatic wait_end(input bit which, input int limit);
    int n = 0;
    while (!(which ? (done_b || err_b) : (done_a || err_a)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_end_%0d: no seq_done/seq_error within %0d cycles", which, limit);
    end
  endtask

  task automatic wait_we0(input bit which, input logic [34:0] cmd, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(which ? (ifb.command_we0 && ifb.command_in == cmd)
                       : (ifa.command_we0 && ifa.command_in == cmd)) && n < limit);
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL wait_we0_%0d: no we0 with %0h within %0d cycles", which, cmd, limit);
    end
  endtask

  task automatic drain_check(input string name);
    repeat (2) @(negedge clk);
    chk(name, 35'(qa.size() + qb.size()), 35'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 36'd31;
    mem[8'h10] = 36'h8_0020_0040;
    mem[8'h11] = 36'd12;
    mem[8'h20] = 36'd6;
    mem[8'h30] = 36'd7;
    mem[8'h40] = 36'd20;
    mem[8'h50] = 36'd13;
    mem[8'h60] = 36'd13;
    mem[8'hFF] = 36'd0;
    rst_a = 1'b1; rst_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0;
    sa_a = 8'h0; sa_b = 8'h0;
    dn_a = '0; dn_b = '0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    chk("rst_busy", 35'(busy_a), 35'd0);
    chk("rst_err", 35'({err_a, code_a, done_a}), 35'd0);
    chk("rst_strobes", 35'({ifa.prog_en, ifa.command_we0, ifa.command_we1}), 35'd0);
    chk("rst_cmd", ifa.command_in, 35'd0);

    // Parameter word, copy, halt; copy completes 7 cycles after its we0.
    push(0, EV_WE1, 35'h0_0020_0040);
    push(0, EV_WE0, 35'd12);
    push(0, EV_WE0, 35'd0);
    push(0, EV_DONE, 35'h12);
    pulse_start(0, 8'h10);
    wait_we0(0, 35'd12, 50);
    repeat (7) @(negedge clk);
    dn_a[6] = 1'b1;
    wait_end(0, 50);
    dn_a[6] = 1'b0;
    drain_check("q_copy");
    chk("idle_busy", 35'(busy_a), 35'd0);

    // vmul waits on its own done line, not on shake.
    dn_a[0] = 1'b1;
    push(0, EV_WE0, 35'd6);
    push(0, EV_WE0, 35'd0);
    push(0, EV_DONE, 35'h21);
    pulse_start(0, 8'h20);
    wait_we0(0, 35'd6, 50);
    repeat (40) @(negedge clk);
    dn_a[1] = 1'b1;
    wait_end(0, 100);
    dn_a = '0;
    drain_check("q_vmul");
    chk("vmul_gap", 35'(nop_cyc_a - iss_cyc_a), 35'd41);

    // Done already high: only the guard delays the clear (ISSUE, 2x GUARD, WAIT, CLEAR).
    dn_a[2] = 1'b1;
    push(0, EV_WE0, 35'd7);
    push(0, EV_WE0, 35'd0);
    push(0, EV_DONE, 35'h31);
    pulse_start(0, 8'h30);
    wait_end(0, 50);
    dn_a = '0;
    drain_check("q_guard");
    chk("guard_gap", 35'(nop_cyc_a - iss_cyc_a), 35'd4);

    // Illegal instruction: sticky error, one NOP, start ignored.
    push(0, EV_WE0, 35'd0);
    push(0, EV_ERR, 35'd1);
    pulse_start(0, 8'h40);
    wait_end(0, 50);
    pulse_start(0, 8'h10);
    pulse_start(0, 8'h10);
    repeat (5) @(negedge clk);
    chk("err_busy", 35'(busy_a), 35'd1);
    chk("err_flag", 35'({err_a, code_a}), 35'b101);
    chk("err_no_fetch", 35'(ifa.prog_en), 35'd0);
    drain_check("q_illegal");
    pulse_rst(0);
    chk("err_cleared", 35'({busy_a, err_a, code_a}), 35'd0);

    // Watchdog at 4 bits: 15 WAIT cycles then timeout.
    rst_b = 1'b0;
    push(1, EV_WE0, 35'd13);
    push(1, EV_WE0, 35'd0);
    push(1, EV_ERR, 35'd2);
    pulse_start(1, 8'h50);
    wait_end(1, 100);
    drain_check("q_timeout");
    chk("timeout_gap", 35'(err_cyc_b - iss_cyc_b), 35'd18);
    pulse_rst(1);
    // Done arriving in the final WAIT cycle beats the timeout.
    push(1, EV_WE0, 35'd13);
    push(1, EV_WE0, 35'd0);
    push(1, EV_DONE, 35'h51);
    pulse_start(1, 8'h50);
    wait_we0(1, 35'd13, 50);
    repeat (17) @(negedge clk);
    dn_b[7] = 1'b1;
    wait_end(1, 50);
    dn_b = '0;
    drain_check("q_race");
    chk("race_err", 35'(err_b), 35'd0);
    chk("race_gap", 35'(nop_cyc_b - iss_cyc_b), 35'd18);

    // Reset mid-WAIT, then a run that wraps pc from 0xFF to 0x00.
    push(0, EV_WE0, 35'd13);
    pulse_start(0, 8'h60);
    wait_we0(0, 35'd13, 50);
    repeat (10) @(negedge clk);
    pulse_rst(0);
    chk("midrst_ctl", 35'({busy_a, done_a, err_a, code_a}), 35'd0);
    chk("midrst_bus", 35'({ifa.prog_en, ifa.command_we0, ifa.command_we1, ifa.prog_addr}), 35'd0);
    chk("midrst_cmd", ifa.command_in, 35'd0);
    push(0, EV_WE0, 35'd0);
    push(0, EV_DONE, 35'h00);
    pulse_start(0, 8'hFF);
    wait_end(0, 50);
    drain_check("q_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
